// File: rtl/uart_cmd_parser.sv
// Setpoint command decoder behind the UART receiver: parses "S" + three hex digits,
// updates a 12-bit setpoint and answers 'K' (accepted) or '?' (rejected) on the transmitter.
module uart_cmd_parser #(
    parameter int unsigned TIMEOUT_CYCLES = 12000,
    parameter int unsigned CNT_W          = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic [11:0] value,
    output logic        value_stb,
    output logic        err
);

    localparam logic [7:0] CH_S = 8'h53;
    localparam logic [7:0] ACK  = 8'h4B;
    localparam logic [7:0] NAK  = 8'h3F;

    typedef enum logic [1:0] {IDLE, D0, D1, D2} state_t;

    state_t           state;
    logic [11:0]      shreg;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic [7:0]       pend_byte;

    logic             hex_ok_c;
    logic [3:0]       nib_c;
    logic [11:0]      next_shreg_c;

    // ASCII hex digit decode; letters map to 10..15 via their low nibble plus nine
    always_comb begin
        hex_ok_c = 1'b1;
        nib_c    = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            nib_c = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            nib_c = rx_data[3:0] + 4'd9;
        end else begin
            hex_ok_c = 1'b0;
        end
    end

    assign next_shreg_c = {shreg[7:0], nib_c};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            pend      <= 1'b0;
            pend_byte <= 8'h00;
            value     <= 12'h000;
            value_stb <= 1'b0;
            err       <= 1'b0;
            tx_start  <= 1'b0;
            tx_data   <= 8'h00;
        end else begin
            value_stb <= 1'b0;
            err       <= 1'b0;
            tx_start  <= 1'b0;

            // Drain the one-deep reply buffer; a reply queued below in the same cycle overrides pend
            if (pend && !tx_busy) begin
                tx_start <= 1'b1;
                tx_data  <= pend_byte;
                pend     <= 1'b0;
            end

            if (state == IDLE || rx_valid) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (rx_valid && rx_data == CH_S) begin
                        state <= D0;
                        shreg <= '0;
                    end
                end
                default: begin
                    if (rx_valid) begin
                        if (rx_data == CH_S) begin
                            state <= D0;
                            shreg <= '0;
                        end else if (hex_ok_c) begin
                            shreg <= next_shreg_c;
                            if (state == D2) begin
                                value     <= next_shreg_c;
                                value_stb <= 1'b1;
                                pend      <= 1'b1;
                                pend_byte <= ACK;
                                state     <= IDLE;
                            end else begin
                                state <= (state == D0) ? D1 : D2;
                            end
                        end else begin
                            err       <= 1'b1;
                            pend      <= 1'b1;
                            pend_byte <= NAK;
                            state     <= IDLE;
                        end
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Silence has lasted TIMEOUT_CYCLES since the last byte: abort
                        err       <= 1'b1;
                        pend      <= 1'b1;
                        pend_byte <= NAK;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed command table, hand-timed corner sequences,
// and a randomized byte stream compared cycle by cycle against a command-level model.
module tb_uart_cmd_parser;

    localparam int unsigned TIMEOUT = 12000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [11:0] value;
    logic        value_stb;
    logic        err;

    uart_cmd_parser #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(14)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
        .tx_data(tx_data), .tx_start(tx_start), .value(value), .value_stb(value_stb), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_stb, n_err, n_start, n_k, n_q;

    // Event counters, sampled 2 time units after each rising edge
    always @(posedge clk) begin
        #2;
        if (value_stb) n_stb++;
        if (err) n_err++;
        if (tx_start) begin
            n_start++;
            if (tx_data == 8'h4B) n_k++;
            if (tx_data == 8'h3F) n_q++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic clear_counts();
        n_stb = 0; n_err = 0; n_start = 0; n_k = 0; n_q = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send(s[i], gap);
    endtask

    // Command-level reference: digits collected so far, numeric accumulator, silence length
    int          m_ndig;      // -1 when no command is open
    int          m_acc;
    int          m_quiet;
    bit          m_pend;
    logic [7:0]  m_pbyte;
    logic [11:0] e_value;
    logic        e_stb, e_err, e_start;
    logic [7:0]  e_txd;

    function automatic int hexval(input logic [7:0] b);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (b >= "A" && b <= "F") return int'(b) - 55;
        if (b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    task automatic model_init();
        m_ndig = -1; m_acc = 0; m_quiet = 0; m_pend = 0; m_pbyte = 8'h00;
        e_value = 12'h000; e_stb = 0; e_err = 0; e_start = 0; e_txd = 8'h00;
    endtask

    task automatic model_step(input bit rv, input logic [7:0] rb, input bit busy);
        bit         q;
        logic [7:0] qb;
        int         h;
        q = 0; qb = 8'h00;
        e_stb = 0; e_err = 0; e_start = 0;
        if (m_pend && !busy) begin
            e_start = 1; e_txd = m_pbyte; m_pend = 0;
        end
        if (rv) begin
            m_quiet = 0;
            h = hexval(rb);
            if (rb == 8'h53) begin
                m_ndig = 0; m_acc = 0;
            end else if (m_ndig >= 0) begin
                if (h >= 0) begin
                    m_acc = m_acc * 16 + h;
                    m_ndig++;
                    if (m_ndig == 3) begin
                        e_value = 12'(m_acc); e_stb = 1; q = 1; qb = 8'h4B; m_ndig = -1;
                    end
                end else begin
                    e_err = 1; q = 1; qb = 8'h3F; m_ndig = -1;
                end
            end
        end else if (m_ndig >= 0) begin
            m_quiet++;
            if (m_quiet == int'(TIMEOUT)) begin
                e_err = 1; q = 1; qb = 8'h3F; m_ndig = -1; m_quiet = 0;
            end
        end
        if (q) begin
            m_pend = 1; m_pbyte = qb;
        end
    endtask

    typedef struct {
        string       msg;
        logic [11:0] val;
        int          stb;
        int          errs;
        int          k;
        int          q;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         k_found;
        string      hexset;
        bit         rv, busy;
        logic [7:0] rb;

        vecs[0] = '{"S259",   12'h259, 1, 0, 1, 0};
        vecs[1] = '{"S114",   12'h114, 1, 0, 1, 0};
        vecs[2] = '{"S350",   12'h350, 1, 0, 1, 0};
        vecs[3] = '{"s0a3",   12'h350, 0, 0, 0, 0};
        vecs[4] = '{"S1G4",   12'h350, 0, 1, 0, 1};
        vecs[5] = '{"S1S350", 12'h350, 1, 0, 1, 0};
        vecs[6] = '{"S7e2",   12'h7E2, 1, 0, 1, 0};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_value", 32'(value), 32'h0);
        check("rst_flags", {29'd0, value_stb, err, tx_start}, 32'h0);
        check("rst_txdata", 32'(tx_data), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        clear_counts();

        // "S0F7": strobe one cycle after the last digit, 'K' one cycle later
        send_str("S0F", 20);
        @(negedge clk);
        rx_data = "7"; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        check("s0f7_stb", {31'd0, value_stb}, 32'd1);
        check("s0f7_value", 32'(value), 32'h0F7);
        check("s0f7_start_early", {31'd0, tx_start}, 32'd0);
        @(negedge clk);
        check("s0f7_start", {31'd0, tx_start}, 32'd1);
        check("s0f7_txdata", 32'(tx_data), 32'h4B);
        check("s0f7_stb_off", {31'd0, value_stb}, 32'd0);
        repeat (5) @(negedge clk);
        check("s0f7_counts", {n_stb[7:0], n_err[7:0], n_k[7:0], n_start[7:0]}, 32'h01_00_01_01);

        // Table of complete command strings
        for (int v = 0; v < 7; v++) begin
            clear_counts();
            send_str(vecs[v].msg, 20);
            repeat (5) @(negedge clk);
            check({"tbl_value_", vecs[v].msg}, 32'(value), 32'(vecs[v].val));
            check({"tbl_stb_", vecs[v].msg}, n_stb, vecs[v].stb);
            check({"tbl_err_", vecs[v].msg}, n_err, vecs[v].errs);
            check({"tbl_k_", vecs[v].msg}, n_k, vecs[v].k);
            check({"tbl_q_", vecs[v].msg}, n_q, vecs[v].q);
        end

        // Timeout after "S3": err exactly TIMEOUT cycles after the '3'
        clear_counts();
        send("S", 20);
        @(negedge clk);
        rx_data = "3"; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        k_found = -1;
        for (int k = 1; k <= int'(TIMEOUT) + 5; k++) begin
            @(negedge clk);
            if (err) begin
                k_found = k;
                break;
            end
        end
        check("timeout_latency", k_found, TIMEOUT);
        repeat (5) @(negedge clk);
        check("timeout_err_count", n_err, 1);
        check("timeout_reply_q", n_q, 1);
        check("timeout_value_kept", 32'(value), 32'h7E2);
        send_str("S0ab", 20);
        repeat (5) @(negedge clk);
        check("after_timeout_value", 32'(value), 32'h0AB);

        // Reply deferred while the transmitter is busy
        clear_counts();
        tx_busy = 1'b1;
        send_str("S1S350", 20);
        repeat (2000) @(negedge clk);
        check("busy_no_start", n_start, 0);
        check("busy_stb", n_stb, 1);
        check("busy_value", 32'(value), 32'h350);
        tx_busy = 1'b0;
        @(negedge clk);
        check("busy_release_start", {31'd0, tx_start}, 32'd1);
        check("busy_release_txdata", 32'(tx_data), 32'h4B);
        @(negedge clk);
        check("busy_start_pulse", {31'd0, tx_start}, 32'd0);
        repeat (5) @(negedge clk);
        check("busy_one_k", n_k, 1);

        // Reset in the middle of a command
        clear_counts();
        send_str("S25", 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_value", 32'(value), 32'h0);
        check("midrst_txdata", 32'(tx_data), 32'h0);
        check("midrst_flags", {29'd0, value_stb, err, tx_start}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send("4", 20);
        repeat (20) @(negedge clk);
        check("midrst_quiet", {n_stb[7:0], n_err[7:0], n_start[7:0]}, 32'h0);
        send_str("S059", 20);
        repeat (5) @(negedge clk);
        check("midrst_value_after", 32'(value), 32'h059);
        check("midrst_k", n_k, 1);

        // Randomized stream against the model, compared every cycle
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0; tx_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_init();
        hexset = "0123456789ABCDEFabcdef";
        busy = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            check("rand_cycle", {9'd0, value, value_stb, err, tx_start, tx_data},
                  {9'd0, e_value, e_stb, e_err, e_start, e_txd});
            rv = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 9))
                0, 1:       rb = 8'h53;
                8, 9:       rb = 8'($urandom_range(0, 255));
                default:    rb = hexset[$urandom_range(0, 21)];
            endcase
            if ($urandom_range(0, 7) == 0) busy = ~busy;
            rx_valid = rv; rx_data = rb; tx_busy = busy;
            model_step(rv, rb, busy);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        tx_busy  = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
